// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the Booth multiply / restoring divide sequencer:
//   FSM state encoding, operation encodings, bit positions of the nine
//   datapath control lines (c0..c8) and the default iteration count.
//   No ports; imported by alu_seq_ctrl and alu_iter_counter.
package alu_ctrl_pkg;

  // Default number of iterations, equal to the datapath word width.
  localparam int ITER_DEFAULT = 64;

  // Operation encodings seen on the op input.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Bit positions inside the ctrl bus (bit i drives datapath line ci).
  localparam int CTRL_W  = 9;
  localparam int C_LOAD  = 0;  // A<=0, Q<=X, M<=Y, Q-1<=0, counter<=0
  localparam int C_ADD   = 1;  // A<=A+M
  localparam int C_SUB   = 2;  // A<=A-M
  localparam int C_ASR   = 3;  // arithmetic shift right A.Q.Q-1
  localparam int C_INC   = 4;  // counter+1
  localparam int C_SHL   = 5;  // shift left A.Q
  localparam int C_QSET  = 6;  // Q[0]<=1
  localparam int C_OUT_A = 7;  // drive A onto the output bus
  localparam int C_OUT_Q = 8;  // drive Q onto the output bus

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CHK,
    MUL_ADD,
    MUL_SHR,
    DIV_SHL,
    DIV_SUB,
    DIV_FIX,
    OUT_HI,
    OUT_LO
  } state_t;

endpackage

// File: rtl/alu_iter_counter.sv
// alu_iter_counter
//   Iteration counter for the sequencer. Counts 0..ITER-1 and wraps to 0.
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset, forces count to 0
//     clear      in   synchronous clear (driven by the load control c0)
//     inc        in   advance the count by one (driven by c4)
//     count_last out  high while the count equals ITER-1
module alu_iter_counter
  import alu_ctrl_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic count_last
);

  localparam int W = (ITER > 1) ? $clog2(ITER) : 1;

  logic [W-1:0] count;

  assign count_last = (count == W'(ITER - 1));

  // Count register. Clear wins over increment; the explicit wrap keeps the
  // counter correct even when ITER is not a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count_last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Control sequencer for a shared datapath that performs either a signed
//   Booth radix-2 multiply or an unsigned restoring divide. It holds only
//   control state (FSM, latched op, error flag, iteration counter).
//   Ports:
//     clk     in   rising-edge clock
//     rst     in   synchronous active-high reset
//     start   in   operation request, honoured only in IDLE
//     op      in   0 = multiply, 1 = divide (latched on start)
//     q0_qm1  in   {Q[0], Q[-1]} from the datapath for Booth decisions
//     a_sign  in   A[64] after the divide trial subtraction
//     m_zero  in   datapath M register is zero
//     ctrl    out  datapath control lines c0..c8
//     busy    out  high from LOAD through OUT_LO
//     done    out  one-cycle pulse in OUT_LO
//     err     out  pulses with done when a divide by zero was detected
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [1:0]        q0_qm1,
  input  logic              a_sign,
  input  logic              m_zero,
  output logic [CTRL_W-1:0] ctrl,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t state_q, state_d;
  logic   op_q;
  logic   err_q;
  logic   set_err;
  logic   count_last;

  // The counter is cleared by the same load pulse that initialises the
  // datapath, so every operation starts counting from zero.
  alu_iter_counter #(
    .ITER (ITER)
  ) u_iter_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (ctrl[C_LOAD]),
    .inc        (ctrl[C_INC]),
    .count_last (count_last)
  );

  // State register plus the two pieces of per-operation state: the op
  // captured when start is accepted, and the divide-by-zero flag that is
  // raised in CHK and reported (then dropped) in OUT_LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        op_q <= op;
      end
      if (state_q == OUT_LO) begin
        err_q <= 1'b0;
      end else if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next-state and control decode. ctrl depends on the current state and
  // the same-cycle datapath flags; everything defaults to zero so only the
  // lines explicitly named for a state are ever asserted.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    set_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        ctrl[C_LOAD] = 1'b1;
        state_d      = CHK;
      end
      CHK: begin
        if (op_q == OP_DIV) begin
          if (m_zero) begin
            set_err = 1'b1;
            state_d = OUT_HI;
          end else begin
            state_d = DIV_SHL;
          end
        end else begin
          state_d = MUL_ADD;
        end
      end
      MUL_ADD: begin
        // Booth recoding: 01 adds M, 10 subtracts M, 00/11 do nothing.
        if (q0_qm1 == 2'b01) ctrl[C_ADD] = 1'b1;
        if (q0_qm1 == 2'b10) ctrl[C_SUB] = 1'b1;
        state_d = MUL_SHR;
      end
      MUL_SHR: begin
        ctrl[C_ASR] = 1'b1;
        ctrl[C_INC] = 1'b1;
        state_d     = count_last ? OUT_HI : MUL_ADD;
      end
      DIV_SHL: begin
        ctrl[C_SHL] = 1'b1;
        state_d     = DIV_SUB;
      end
      DIV_SUB: begin
        ctrl[C_SUB] = 1'b1;
        state_d     = DIV_FIX;
      end
      DIV_FIX: begin
        // A negative trial remainder is restored; otherwise the quotient
        // bit just shifted in becomes a one.
        ctrl[C_INC] = 1'b1;
        if (a_sign) ctrl[C_ADD]  = 1'b1;
        else        ctrl[C_QSET] = 1'b1;
        state_d = count_last ? OUT_HI : DIV_SHL;
      end
      OUT_HI: begin
        ctrl[C_OUT_A] = 1'b1;
        state_d       = OUT_LO;
      end
      OUT_LO: begin
        ctrl[C_OUT_Q] = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == OUT_LO);
  assign err  = (state_q == OUT_LO) && err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Self-checking bench for alu_seq_ctrl. A behavioural 64-bit datapath
//   (Booth multiply / restoring divide) reacts to the DUT's ctrl lines and
//   feeds back q0_qm1, a_sign and m_zero; directed vectors and sequences
//   compare every output against hand-derived expectations.
module tb_alu_seq_ctrl;
  import alu_ctrl_pkg::*;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        op    = 1'b0;
  logic [1:0]  q0_qm1;
  logic        a_sign;
  logic        m_zero;
  logic [8:0]  ctrl;
  logic        busy;
  logic        done;
  logic        err;

  // Behavioural datapath state.
  logic [64:0] m_a    = '0;
  logic [63:0] m_q    = '0;
  logic [63:0] m_m    = '0;
  logic        m_qm1  = 1'b0;
  logic        m_div  = 1'b0;
  logic [63:0] cur_x  = '0;
  logic [63:0] cur_y  = '0;

  // Forced flag values used by the vector table instead of the model.
  logic        use_model = 1'b0;
  logic [1:0]  q_force   = 2'b00;
  logic        a_force   = 1'b0;
  logic        mz_force  = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string          name;
    logic           op;
    logic           mz;
    logic [1:0]     q;
    logic           as;
    logic [4:0][8:0] ctrl_exp;  // index k-1 for cycles T+1..T+5
    logic           done4;
    logic           err4;
    logic           busy5;
  } vec_t;

  vec_t tbl [7];

  alu_seq_ctrl #(.ITER(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .q0_qm1 (q0_qm1),
    .a_sign (a_sign),
    .m_zero (m_zero),
    .ctrl   (ctrl),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  assign q0_qm1 = use_model ? {m_q[0], m_qm1} : q_force;
  assign a_sign = use_model ? m_a[64] : a_force;
  assign m_zero = use_model ? (m_m == 64'd0) : mz_force;

  function automatic logic [64:0] sx65(input logic [63:0] v);
    return {v[63], v};
  endfunction

  // Datapath model: applies the control lines present before each edge.
  // Multiply keeps A sign-extended to 65 bits; divide uses A[64] as the
  // borrow/sign of the trial subtraction.
  always @(posedge clk) begin
    if (ctrl[C_LOAD]) begin
      m_a   <= '0;
      m_q   <= cur_x;
      m_m   <= cur_y;
      m_qm1 <= 1'b0;
    end else if (ctrl[C_ADD]) begin
      m_a <= m_div ? m_a + {1'b0, m_m} : sx65(m_a[63:0] + m_m);
    end else if (ctrl[C_SUB]) begin
      m_a <= m_div ? m_a - {1'b0, m_m} : sx65(m_a[63:0] - m_m);
    end else if (ctrl[C_ASR]) begin
      {m_a, m_q, m_qm1} <= {m_a[64], m_a, m_q};
    end else if (ctrl[C_SHL]) begin
      {m_a, m_q} <= {m_a[63:0], m_q, 1'b0};
    end
    if (ctrl[C_QSET]) m_q[0] <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected ctrl for cycle T+k of a full operation whose done cycle is
  // T+last; Booth and divide decisions come from the model's flags.
  function automatic logic [8:0] expectedCtrl(input logic is_div, input int last, input int k);
    logic [8:0] e = '0;
    if (k == 1) e[C_LOAD] = 1'b1;
    else if (k == last - 1) e[C_OUT_A] = 1'b1;
    else if (k == last) e[C_OUT_Q] = 1'b1;
    else if (k >= 3 && k < last - 1) begin
      if (!is_div) begin
        if ((k % 2) == 1) begin
          if ({m_q[0], m_qm1} == 2'b01) e[C_ADD] = 1'b1;
          if ({m_q[0], m_qm1} == 2'b10) e[C_SUB] = 1'b1;
        end else begin
          e[C_ASR] = 1'b1;
          e[C_INC] = 1'b1;
        end
      end else begin
        case ((k - 3) % 3)
          0: e[C_SHL] = 1'b1;
          1: e[C_SUB] = 1'b1;
          default: begin
            e[C_INC] = 1'b1;
            if (m_a[64]) e[C_ADD] = 1'b1;
            else         e[C_QSET] = 1'b1;
          end
        endcase
      end
    end
    return e;
  endfunction

  // Runs one operation against the model, checking {busy,done,err,ctrl}
  // every cycle from T+1 to T+last+1 and capturing the output bus.
  task automatic runOp(input string tag, input logic op_in, input logic [63:0] x, input logic [63:0] y,
                       input logic hold_start, input int last,
                       output logic [63:0] hi_out, output logic [63:0] lo_out, output int fix_count);
    logic [11:0] exp_v;
    cur_x = x;
    cur_y = y;
    m_div = op_in;
    use_model = 1'b1;
    hi_out = '0;
    lo_out = '0;
    fix_count = 0;
    @(negedge clk);
    op = op_in;
    start = 1'b1;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      exp_v = {(k <= last), (k == last), (last == 4 && k == last), expectedCtrl(op_in, last, k)};
      checkOutput($sformatf("%s_cyc%0d", tag, k), {52'd0, busy, done, err, ctrl}, {52'd0, exp_v});
      if (ctrl[C_OUT_A]) hi_out = m_a[63:0];
      if (ctrl[C_OUT_Q]) lo_out = m_q;
      if (m_div && ctrl[C_INC]) fix_count++;
      if (k == 1 && !hold_start) begin
        start = 1'b0;
        op = ~op_in;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    use_model = 1'b0;
    q_force = v.q;
    a_force = v.as;
    mz_force = v.mz;
    op = v.op;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_ctrl_k%0d", v.name, k), {55'd0, ctrl}, {55'd0, v.ctrl_exp[k-1]});
      if (k == 4) checkOutput($sformatf("%s_done_err_k4", v.name), {62'd0, done, err}, {62'd0, v.done4, v.err4});
      if (k == 5) checkOutput($sformatf("%s_busy_k5", v.name), {63'd0, busy}, {63'd0, v.busy5});
      if (k == 1) begin
        start = 1'b0;
        op = ~v.op;
      end
    end
  endtask

  function automatic vec_t mkVec(input string name, input logic op_i, input logic mz, input logic [1:0] q,
                                 input logic as, input logic [8:0] c1, input logic [8:0] c2,
                                 input logic [8:0] c3, input logic [8:0] c4, input logic [8:0] c5,
                                 input logic d4, input logic e4, input logic b5);
    vec_t v;
    v.name = name;
    v.op = op_i;
    v.mz = mz;
    v.q = q;
    v.as = as;
    v.ctrl_exp = {c5, c4, c3, c2, c1};
    v.done4 = d4;
    v.err4 = e4;
    v.busy5 = b5;
    return v;
  endfunction

  // Top-level test sequence.
  initial begin
    logic [63:0] hi, lo;
    int fixes;

    tbl[0] = mkVec("mul_q01", 1'b0, 1'b0, 2'b01, 1'b0, 9'h001, 9'h000, 9'h002, 9'h018, 9'h002, 1'b0, 1'b0, 1'b1);
    tbl[1] = mkVec("mul_q10", 1'b0, 1'b0, 2'b10, 1'b0, 9'h001, 9'h000, 9'h004, 9'h018, 9'h004, 1'b0, 1'b0, 1'b1);
    tbl[2] = mkVec("mul_q00", 1'b0, 1'b0, 2'b00, 1'b0, 9'h001, 9'h000, 9'h000, 9'h018, 9'h000, 1'b0, 1'b0, 1'b1);
    tbl[3] = mkVec("mul_q11", 1'b0, 1'b0, 2'b11, 1'b0, 9'h001, 9'h000, 9'h000, 9'h018, 9'h000, 1'b0, 1'b0, 1'b1);
    tbl[4] = mkVec("div_neg", 1'b1, 1'b0, 2'b00, 1'b1, 9'h001, 9'h000, 9'h020, 9'h004, 9'h012, 1'b0, 1'b0, 1'b1);
    tbl[5] = mkVec("div_pos", 1'b1, 1'b0, 2'b00, 1'b0, 9'h001, 9'h000, 9'h020, 9'h004, 9'h050, 1'b0, 1'b0, 1'b1);
    tbl[6] = mkVec("div_zero", 1'b1, 1'b1, 2'b00, 1'b0, 9'h001, 9'h000, 9'h080, 9'h100, 9'h000, 1'b1, 1'b1, 1'b0);

    // Reset held with start asserted: everything must stay quiet.
    rst = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {52'd0, busy, done, err, ctrl}, 64'd0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", {52'd0, busy, done, err, ctrl}, 64'd0);

    for (int i = 0; i < 7; i++) applyStimulus(tbl[i]);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Full multiply 3 * -2.
    runOp("mul", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 132, hi, lo, fixes);
    checkOutput("mul_hi", hi, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("mul_lo", lo, 64'hFFFF_FFFF_FFFF_FFFA);

    // Full divide 100 / 7.
    runOp("div", OP_DIV, 64'd100, 64'd7, 1'b0, 196, hi, lo, fixes);
    checkOutput("div_quot", lo, 64'd14);
    checkOutput("div_rem", hi, 64'd2);
    checkOutput("div_fix_cycles", 64'(fixes), 64'd64);

    // Divide by zero: straight to output with err.
    runOp("divz", OP_DIV, 64'd100, 64'd0, 1'b0, 4, hi, lo, fixes);
    checkOutput("divz_fix_cycles", 64'(fixes), 64'd0);

    // Reset in the middle of multiply iteration 20, then a clean rerun.
    cur_x = 64'd3;
    cur_y = 64'hFFFF_FFFF_FFFF_FFFE;
    m_div = 1'b0;
    use_model = 1'b1;
    @(negedge clk);
    op = OP_MUL;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (42) @(negedge clk);
    checkOutput("mid_mul_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_outputs", {52'd0, busy, done, err, ctrl}, 64'd0);
    rst = 1'b0;
    runOp("mul_after_rst", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 132, hi, lo, fixes);
    checkOutput("mul_after_rst_lo", lo, 64'hFFFF_FFFF_FFFF_FFFA);

    // start held high: no restart while busy, new LOAD two cycles after done.
    runOp("mul_hold", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 132, hi, lo, fixes);
    @(negedge clk);
    checkOutput("hold_second_load", {54'd0, busy, ctrl}, {54'd0, 1'b1, 9'h001});
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The module SHALL have port: clk  input  1  system clock, all state changes on rising edge.
REQ-002 The module SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 The module SHALL have port: start  input  1  operation request, sampled only in IDLE.
REQ-004 The module SHALL have port: op  input  1  0 = signed multiply (Booth radix-2), 1 = unsigned restoring divide.
REQ-005 The module SHALL have port: q0_qm1  input  2  datapath {Q[0], Q[-1]} for Booth decisions.
REQ-006 The module SHALL have port: a_sign  input  1  datapath A[64] sign after the divide trial subtraction.
REQ-007 The module SHALL have port: m_zero  input  1  datapath M register equals zero.
REQ-008 The module SHALL have port: ctrl  output  9  datapath controls c0..c8 (bit i = ci).
REQ-009 The module SHALL have port: busy  output  1  high from LOAD through OUT_LO inclusive.
REQ-010 The module SHALL have port: done  output  1  one-cycle pulse in OUT_LO.
REQ-011 The module SHALL have port: err  output  1  one-cycle pulse with done on divide-by-zero.
REQ-012 The module SHALL have parameter: ITER, default 64, iteration count (word width).

Function
REQ-013 Control meanings SHALL be: c0 load (A<=0, Q<=X, M<=Y, Q-1<=0, counter<=0); c1 A<=A+M; c2 A<=A-M; c3 arith shift right A.Q.Q-1; c4 counter+1; c5 shift left A.Q; c6 Q[0]<=1; c7 drive A to outbus; c8 drive Q to outbus.
REQ-014 States SHALL be IDLE, LOAD, CHK, MUL_ADD, MUL_SHR, DIV_SHL, DIV_SUB, DIV_FIX, OUT_HI, OUT_LO.
REQ-015 IDLE: op latched and transition to LOAD when start=1; otherwise stay; ctrl=0.
REQ-016 LOAD: c0 only; next CHK.
REQ-017 CHK: ctrl=0; op=1 and m_zero=1 -> OUT_HI with error flag set; op=1 otherwise -> DIV_SHL; op=0 -> MUL_ADD.
REQ-018 MUL_ADD: q0_qm1=01 -> c1, 10 -> c2, 00/11 -> none; next MUL_SHR.
REQ-019 MUL_SHR: c3 and c4; counter at ITER-1 (before increment) -> OUT_HI, else MUL_ADD.
REQ-020 DIV_SHL: c5; next DIV_SUB. DIV_SUB: c2; next DIV_FIX.
REQ-021 DIV_FIX: c4 plus c1 if a_sign=1 else c6; counter at ITER-1 -> OUT_HI, else DIV_SHL.
REQ-022 OUT_HI: c7; next OUT_LO. OUT_LO: c8, done=1, err=error flag; next IDLE; error flag cleared.
REQ-023 ctrl SHALL be combinational from current state and same-cycle q0_qm1/a_sign; all other outputs registered-state decoded.
REQ-024 With start sampled at cycle T: LOAD T+1, CHK T+2, done at T+132 (mul), T+196 (div), T+4 (div by zero).
REQ-025 start while busy SHALL be ignored; start in the cycle after OUT_LO SHALL begin a new operation.
REQ-026 Counter SHALL be 6-bit (log2 ITER), wrap to 0 after ITER-1; count_last = (counter == ITER-1).
REQ-027 Outside the listed assertions every ctrl bit SHALL be 0; at most one of c1/c2 per cycle.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, counter=0, error flag=0, op latch=0, from any state including mid-iteration.
REQ-029 During and after reset until next start: ctrl=0, busy=0, done=0, err=0.

Structure
REQ-030 Package alu_ctrl_pkg SHALL hold the state enumeration, op encodings, c0..c8 bit-index constants and default ITER.
REQ-031 Iteration counter SHALL be one sub-module alu_iter_counter (clear, inc, count_last).
REQ-032 No datapath registers SHALL reside in alu_seq_ctrl.

Verification
REQ-033 Mul, q0_qm1 driven by a 64-bit Booth model with X=3, Y=-2: c1/c2 pattern matches model, product -6 across OUT_HI/OUT_LO, done at T+132.
REQ-034 Div X=100, Y=7 with a_sign from model: quotient 14, remainder 2, exactly 64 DIV_FIX cycles, done at T+196, err=0.
REQ-035 Div Y=0 (m_zero=1): no c5/c2 issued, c7 at T+3, done=err=1 at T+4.
REQ-036 rst asserted at mul iteration 20: next cycle IDLE, ctrl=0, busy=0; new start runs full 64 iterations.
REQ-037 start held high throughout a mul: no restart while busy; second op's LOAD at cycle after OUT_LO+1.
